// File: rtl/bram_ctrl_pkg.sv
// Shared widths, depth and FSM state encoding for the BRAM record/playback controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  // Word count runs 0..DEPTH inclusive, so it needs one bit more than the address.
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_SHOW = 2'd3
  } state_t;

  // Stored-word count saturates at DEPTH once the ring has wrapped.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(DEPTH)) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bram_ctrl_if.sv
// Port-A bundle between the controller and the external single-port BRAM.
// Latency: douta is registered in the memory, valid one edge after addra is sampled.
// Backpressure: none; the memory accepts an access every cycle.
interface bram_ctrl_if;
  import bram_ctrl_pkg::*;

  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    output wea,
    output addra,
    output dina,
    input  douta
  );

  modport slave (
    input  wea,
    input  addra,
    input  dina,
    output douta
  );

endinterface

// File: rtl/bram_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample debouncer, rising-edge pulse.
// Latency: pulse appears 2 + DEB_CYCLES edges after the raw input settles high.
// Backpressure: none; the pulse is one cycle wide and is not held for the consumer.
module btn_debounce
  import bram_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DC_W-1:0] stab_q, stab_d;

  // Synchronize the raw button into the CLK domain.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; flip after DEB_CYCLES of them.
  always_comb begin
    level_d = level_q;
    stab_d  = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (stab_q == DC_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        // Only the low-to-high acceptance is a press.
        pulse_d = sync2_q;
      end else begin
        stab_d = stab_q + DC_W'(1);
      end
    end
  end

  // Debounced level, stability counter and press pulse registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      level_q <= 1'b0;
      stab_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      stab_q  <= stab_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/bram_ctrl.sv
// Records SW words into an external 16-deep BRAM on write presses and replays them on LED.
// Latency: write lands the cycle after the press pulse; each replayed word is a 1-cycle address phase plus STEP_CYCLES hold.
// Backpressure: none; write presses during playback are dropped, a play press during playback aborts it.
module bram_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] SW,
  input  logic              BTN_WR,
  input  logic              BTN_PLAY,
  bram_ctrl_if.master       mem,
  output logic [DATA_W-1:0] LED,
  output logic [CNT_W-1:0]  CNT,
  output logic              BUSY
);

  localparam int HOLD_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              wr_pulse;
  logic              play_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_wr (
    .CLK     (CLK),
    .CLR     (CLR),
    .btn_i   (BTN_WR),
    .pulse_o (wr_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
    .CLK     (CLK),
    .CLR     (CLR),
    .btn_i   (BTN_PLAY),
    .pulse_o (play_pulse)
  );

  // Next-state logic: record, sequential playback of 0..CNT-1, abort on a second play press.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    // Hold counter restarts from zero on every state entry and only runs while showing a word.
    hold_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Write wins a tie; the simultaneous play pulse is simply not acted on.
        if (wr_pulse) begin
          state_d = ST_WRITE;
        end else if (play_pulse && (cnt_q != '0)) begin
          state_d  = ST_RD_ADDR;
          rd_ptr_d = '0;
        end
      end
      ST_WRITE: begin
        led_d    = SW;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        cnt_d    = cnt_sat_inc(cnt_q);
        state_d  = ST_IDLE;
      end
      ST_RD_ADDR: begin
        if (play_pulse) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_SHOW;
        end
      end
      ST_RD_SHOW: begin
        if (play_pulse) begin
          // Abort leaves LED untouched, even on the cycle that would have loaded douta.
          state_d = ST_IDLE;
        end else begin
          if (hold_q == '0) begin
            led_d = mem.douta;
          end
          if (hold_q == HOLD_W'(STEP_CYCLES - 1)) begin
            if ({1'b0, rd_ptr_q} == (cnt_q - CNT_W'(1))) begin
              state_d = ST_IDLE;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_W'(1);
              state_d  = ST_RD_ADDR;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state, pointers, word count, display and hold counter.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      hold_q   <= hold_d;
    end
  end

  // Memory port decode: the read pointer owns the address for the whole playback so douta stays stable.
  always_comb begin
    BUSY      = (state_q == ST_RD_ADDR) || (state_q == ST_RD_SHOW);
    mem.wea   = (state_q == ST_WRITE);
    mem.dina  = (state_q == ST_WRITE) ? SW : '0;
    mem.addra = BUSY ? rd_ptr_q : wr_ptr_q;
  end

  assign LED = led_q;
  assign CNT = cnt_q;

endmodule

// File: doc/bram_ctrl.md
BRAM_CTRL -- requirements
Module: bram_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 50000, number of consecutive stable samples a button needs before its level is accepted.
REQ-002 Parameter: STEP_CYCLES, default 25000000, number of cycles each read-back word is held on LED during playback.
REQ-003 Clocking: one clock, CLK; reset CLR is asynchronous and active-high.
REQ-004 Port: CLK  input  1  system clock, also drives the memory clock port.
REQ-005 Port: CLR  input  1  asynchronous active-high reset.
REQ-006 Port: SW  input  8  data to store.
REQ-007 Port: BTN_WR  input  1  raw write button, asynchronous to CLK.
REQ-008 Port: BTN_PLAY  input  1  raw playback button, asynchronous to CLK.
REQ-009 Port: douta  input  8  memory read data, registered inside the memory, valid one CLK edge after addra is sampled.
REQ-010 Port: wea  output  1  memory write enable.
REQ-011 Port: addra  output  4  memory address.
REQ-012 Port: dina  output  8  memory write data.
REQ-013 Port: LED  output  8  displayed data.
REQ-014 Port: CNT  output  5  number of valid stored words, 0..16.
REQ-015 Port: BUSY  output  1  high while playback is active.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; a press SHALL be a one-cycle pulse on the rising edge of the debounced level.
REQ-017 The FSM SHALL have four states: IDLE, WRITE, RD_ADDR, RD_SHOW.
REQ-018 IDLE + write pulse -> WRITE, which lasts exactly one cycle: wea=1, addra=wr_ptr, dina=SW, LED<=SW; then return to IDLE.
REQ-019 In WRITE, wr_ptr SHALL increment modulo 16 (15 -> 0 wrap, older data overwritten), and CNT SHALL increment saturating at 16.
REQ-020 IDLE + play pulse with CNT>0 -> RD_ADDR with rd_ptr=0; with CNT=0 the pulse SHALL be ignored.
REQ-021 RD_ADDR (one cycle): addra=rd_ptr, wea=0; then -> RD_SHOW.
REQ-022 RD_SHOW: on its first cycle LED<=douta; hold for STEP_CYCLES cycles; then if rd_ptr=CNT-1 -> IDLE, else rd_ptr+1 -> RD_ADDR.
REQ-023 Playback order SHALL be address 0..CNT-1, regardless of wr_ptr.
REQ-024 Outside WRITE, wea SHALL be 0.
REQ-025 Outside RD_ADDR/RD_SHOW, addra SHALL equal wr_ptr.
REQ-026 BUSY=1 exactly in RD_ADDR and RD_SHOW.
REQ-027 A play pulse while BUSY SHALL abort playback to IDLE next cycle; LED SHALL keep its last value.
REQ-028 A write pulse while BUSY SHALL be discarded, not queued.
REQ-029 Simultaneous write and play pulses in IDLE: write wins, and the play pulse is discarded.
REQ-030 Hold-time counter SHALL be wide enough for STEP_CYCLES and SHALL be cleared on every state entry.

Reset
REQ-031 CLR SHALL asynchronously force: state=IDLE, wr_ptr=0, rd_ptr=0, CNT=0, LED=0, wea=0, dina=0, addra=0, BUSY=0, synchronizers and debouncers to 0.
REQ-032 CLR mid-write or mid-playback SHALL abandon the operation; memory contents are not cleared, but CNT=0 makes them unreachable until rewritten.
REQ-033 Release of CLR SHALL NOT generate a button pulse even if a button is held; a held button SHALL first read as debounced-high only after DEB_CYCLES, and that produces one pulse.

Structure
REQ-034 A shared include file SHALL hold ADDR_W=4, DATA_W=8, DEPTH=16 and the state encodings.
REQ-035 Sub-module btn_debounce (synchronizer + stable counter + rising-edge pulse, parameter DEB_CYCLES) SHALL be instantiated twice.
REQ-036 The memory itself SHALL stay outside this block, connected through wea/addra/dina/douta.

Verification (DEB_CYCLES=4, STEP_CYCLES=8, 1-cycle-latency memory model)
REQ-037 Write SW=0xA5, 0x3C, 0xFF via three presses -> wea pulses of 1 cycle at addra 0,1,2 with matching dina; CNT=3.
REQ-038 Then play -> LED shows 0xA5, 0x3C, 0xFF, each for 8 cycles; BUSY high throughout, low after the third; addra sequence 0,1,2.
REQ-039 17 writes of values 0x00..0x10 -> CNT=16; address 0 holds 0x10; playback first shows 0x10, then 0x01..0x0F.
REQ-040 Play with CNT=0 -> no state change, BUSY stays 0; a 2-cycle glitch on BTN_WR -> no wea pulse.
REQ-041 Press play at CNT=3 and assert CLR during the second word -> all outputs 0 immediately; a following play press is ignored.
REQ-042 Write and play pressed in the same cycle in IDLE -> exactly one write, no playback; play press mid-playback -> IDLE, LED holds.
